// File: rtl/lcd_reader.sv
//==============================================================================
// Module  : lcd_reader
// Brief   : HD44780 4-bit read transaction (busy flag/address or RAM data byte)
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_reader #(
    parameter int T_SETUP = 5,   // 1..255
    parameter int T_EHIGH = 20,  // 1..255
    parameter int T_GAP   = 50,  // 1..255
    parameter int T_HOLD  = 5    // 1..255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       RS_SEL,
    input  logic [3:0] SF_D_IN,
    output logic       SF_D_OE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RD_DATA
);

    // Each phase loads N-1 so it lasts exactly N cycles, leaving on count 0.
    localparam logic [7:0] c_setup_ld = 8'(T_SETUP - 1);
    localparam logic [7:0] c_ehigh_ld = 8'(T_EHIGH - 1);
    localparam logic [7:0] c_gap_ld   = 8'(T_GAP - 1);
    localparam logic [7:0] c_hold_ld  = 8'(T_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_E1    = 3'd2,
        S_GAP   = 3'd3,
        S_E2    = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 8'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            LCD_E   <= 1'b0;
            LCD_RS  <= 1'b0;
            LCD_RW  <= 1'b0;
            SF_D_OE <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RD_DATA <= 8'd0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        LCD_RS  <= RS_SEL;
                        LCD_RW  <= 1'b1;
                        SF_D_OE <= 1'b0;
                        BUSY    <= 1'b1;
                        r_cnt   <= c_setup_ld;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        LCD_E   <= 1'b1;
                        r_cnt   <= c_ehigh_ld;
                        r_state <= S_E1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_E1: begin
                    // Sample on the edge that drops E: data has been valid the longest.
                    if (w_cnt_zero) begin
                        LCD_E        <= 1'b0;
                        RD_DATA[7:4] <= SF_D_IN;
                        r_cnt        <= c_gap_ld;
                        r_state      <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        LCD_E   <= 1'b1;
                        r_cnt   <= c_ehigh_ld;
                        r_state <= S_E2;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_E2: begin
                    if (w_cnt_zero) begin
                        LCD_E        <= 1'b0;
                        RD_DATA[3:0] <= SF_D_IN;
                        r_cnt        <= c_hold_ld;
                        r_state      <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        LCD_RW  <= 1'b0;
                        LCD_RS  <= 1'b0;
                        SF_D_OE <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_reader.sv
//==============================================================================
// Module  : tb_lcd_reader
// Brief   : Randomized self-checking bench for lcd_reader against a timing model
// Rev     : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_reader;

    localparam int T_SETUP = 5;
    localparam int T_EHIGH = 20;
    localparam int T_GAP   = 50;
    localparam int T_HOLD  = 5;
    localparam int LAT     = T_SETUP + 2 * T_EHIGH + T_GAP + T_HOLD;
    localparam int CAP_HI  = T_SETUP + T_EHIGH;           // edge capturing the high nibble
    localparam int CAP_LO  = CAP_HI + T_GAP + T_EHIGH;    // edge capturing the low nibble
    localparam int NO_PULSE = -100;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       RS_SEL = 1'b0;
    logic [3:0] SF_D_IN = 4'd0;
    logic       SF_D_OE, LCD_E, LCD_RS, LCD_RW, BUSY, DONE;
    logic [7:0] RD_DATA;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] last_rd = 8'd0;

    lcd_reader #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_GAP   (T_GAP),
        .T_HOLD  (T_HOLD)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .RS_SEL  (RS_SEL),
        .SF_D_IN (SF_D_IN),
        .SF_D_OE (SF_D_OE),
        .LCD_E   (LCD_E),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RD_DATA (RD_DATA)
    );

    always #10 CLK = ~CLK;

    // E is high for T_EHIGH cycles after the setup time, and again after the gap.
    function automatic logic model_e(input int j);
        return (j >= T_SETUP && j < CAP_HI) || (j >= CAP_HI + T_GAP && j < CAP_LO);
    endfunction

    // Runs one read; called and returning at a falling edge. Cycle j is the
    // interval after rising edge j, where edge 0 accepts START.
    task automatic do_read(input logic rs, input logic [7:0] data, input bit glitch,
                           input bit hold, input int pulse_at, input int abort_at);
        logic [5:0] exp_ctl;
        logic [5:0] act_ctl;
        logic [7:0] exp_rd;
        int         rw_rise;
        START   = 1'b1;
        RS_SEL  = rs;
        SF_D_IN = 4'($urandom);
        rw_rise = -1;
        for (int j = 0; j <= LAT + 1; j++) begin
            @(negedge CLK);
            if (j < LAT)       exp_ctl = {model_e(j), rs, 1'b1, 1'b0, 1'b1, 1'b0};
            else if (j == LAT) exp_ctl = 6'b000101;
            else               exp_ctl = 6'b000100;
            if (j < CAP_HI)      exp_rd = last_rd;
            else if (j < CAP_LO) exp_rd = {data[7:4], last_rd[3:0]};
            else                 exp_rd = data;
            act_ctl = {LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE};
            vectors++;
            if (act_ctl !== exp_ctl || RD_DATA !== exp_rd) begin
                miscompares++;
                $display("FAIL read_cycle j=%0d: E,RS,RW,OE,BUSY,DONE=%b RD_DATA=%h, expected %b %h",
                         j, act_ctl, RD_DATA, exp_ctl, exp_rd);
            end
            vectors++;
            if (LCD_RW === 1'b1 && SF_D_OE !== 1'b0) begin
                miscompares++;
                $display("FAIL oe_vs_rw j=%0d: SF_D_OE=%b with LCD_RW=1, expected 0", j, SF_D_OE);
            end
            if (LCD_RW === 1'b1 && rw_rise < 0) rw_rise = j;
            vectors++;
            if (LCD_E === 1'b1 && (rw_rise < 0 || j - rw_rise < T_SETUP)) begin
                miscompares++;
                $display("FAIL e_setup j=%0d: E high %0d cycles after RW rose, expected >= %0d",
                         j, j - rw_rise, T_SETUP);
            end
            if (j == abort_at) return;
            START  = hold || (j == pulse_at - 1) || (j == LAT);
            RS_SEL = 1'($urandom);
            if (j == CAP_HI - 1)
                SF_D_IN = data[7:4];
            else if (j == CAP_LO - 1)
                SF_D_IN = data[3:0];
            else if (j >= T_SETUP && j < CAP_HI)
                SF_D_IN = glitch ? ~data[7:4] : data[7:4];
            else if (j >= CAP_HI + T_GAP && j < CAP_LO)
                SF_D_IN = glitch ? ~data[3:0] : data[3:0];
            else
                SF_D_IN = 4'($urandom);
        end
        last_rd = data;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE} !== 6'b000100 || RD_DATA !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_hold: ctl=%b rd=%h, expected 000100 00",
                     {LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE}, RD_DATA);
        end
        START = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE} !== 6'b000100 || RD_DATA !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_release: ctl=%b rd=%h, expected 000100 00",
                     {LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE}, RD_DATA);
        end
        last_rd = 8'd0;
    endtask

    task automatic test_status_read();
        do_read(1'b0, 8'h83, 1'b0, 1'b0, NO_PULSE, -1);
    endtask

    task automatic test_data_read();
        do_read(1'b1, 8'h41, 1'b0, 1'b0, NO_PULSE, -1);
    endtask

    task automatic test_capture_glitch();
        do_read(1'($urandom), 8'($urandom), 1'b1, 1'b0, NO_PULSE, -1);
    endtask

    task automatic test_ignored_start();
        do_read(1'b1, 8'($urandom), 1'b0, 1'b0, 30, -1);
    endtask

    task automatic test_back_to_back();
        do_read(1'b0, 8'($urandom), 1'b0, 1'b1, NO_PULSE, -1);
        do_read(1'b1, 8'($urandom), 1'b0, 1'b0, NO_PULSE, -1);
    endtask

    task automatic test_reset_abort();
        do_read(1'b1, 8'hA5, 1'b0, 1'b0, NO_PULSE, 44);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        vectors++;
        if ({LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE} !== 6'b000100 || RD_DATA !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_async: ctl=%b rd=%h, expected 000100 00",
                     {LCD_E, LCD_RS, LCD_RW, SF_D_OE, BUSY, DONE}, RD_DATA);
        end
        repeat (3) @(negedge CLK);
        RST_N   = 1'b1;
        last_rd = 8'd0;
        repeat (LAT + 5) begin
            @(negedge CLK);
            vectors++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_done: DONE=%b BUSY=%b, expected 0 0", DONE, BUSY);
            end
        end
        do_read(1'b0, 8'($urandom), 1'b0, 1'b0, NO_PULSE, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            do_read(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), NO_PULSE, -1);
        do_read(1'($urandom), 8'($urandom), 1'b0, 1'b0, NO_PULSE, -1);
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_data_read();
        test_capture_glitch();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
